// File: rtl/hamming_pkg.sv
// Shared types and helpers for the Hamming frame encoder.
// The Hamming helpers work on fixed maximum widths (26 data bits, 32 code
// bits) so a single package serves every legal DATA_W; callers slice the
// result down to their own codeword width.
package hamming_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ENCODE = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam int MAX_DATA_W = 26;
    localparam int MAX_CODE_W = 32;

    // Smallest P with 2^P >= data_w + P + 1.
    function automatic int parity_count(input int data_w);
        int p;
        p = 1;
        for (int i = 0; i < 5; i++) begin
            if ((1 << p) < data_w + p + 1) begin
                p = p + 1;
            end
        end
        return p;
    endfunction

    // Data bits go to non-power-of-two positions in ascending order; the
    // parity bit at position 2^k is even parity over positions with bit k set.
    // Bit (pos-1) of the result holds Hamming position pos.
    function automatic logic [MAX_CODE_W-1:0] hamming_encode(
        input logic [MAX_DATA_W-1:0] data,
        input int                    data_w
    );
        logic [MAX_CODE_W-1:0] code;
        logic                  par;
        int                    j;
        int                    code_w;
        code   = '0;
        j      = 0;
        code_w = data_w + parity_count(data_w);
        for (int pos = 1; pos <= MAX_CODE_W; pos++) begin
            if (pos <= code_w && (pos & (pos - 1)) != 0) begin
                code[5'(pos - 1)] = data[5'(j)];
                j = j + 1;
            end
        end
        for (int k = 0; k < 5; k++) begin
            par = 1'b0;
            for (int pos = 1; pos <= MAX_CODE_W; pos++) begin
                if (pos <= code_w && ((pos >> k) & 1) == 1) begin
                    par = par ^ code[5'(pos - 1)];
                end
            end
            if ((1 << k) <= code_w) begin
                code[5'((1 << k) - 1)] = par;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/hamming_frame_encoder_key_gen.sv
// Ping-pong key generator: counts up from min to max and back down,
// reversing at each end. Bounds are captured on load so the sequence is
// immune to changes on min/max while a frame is being encoded.
module ping_pong_key_gen #(
    parameter int KEY_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [KEY_W-1:0] min,
    input  logic [KEY_W-1:0] max,
    output logic [KEY_W-1:0] key
);

    logic [KEY_W-1:0] min_q;
    logic [KEY_W-1:0] max_q;
    logic             dir_up;

    // Key and direction update; a degenerate range pins the key to min.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key    <= '0;
            min_q  <= '0;
            max_q  <= '0;
            dir_up <= 1'b1;
        end else if (load) begin
            key    <= min;
            min_q  <= min;
            max_q  <= max;
            dir_up <= 1'b1;
        end else if (step) begin
            if (min_q >= max_q) begin
                key <= min_q;
            end else if (dir_up) begin
                if (key >= max_q) begin
                    key    <= key - KEY_W'(1);
                    dir_up <= 1'b0;
                end else begin
                    key <= key + KEY_W'(1);
                end
            end else begin
                if (key <= min_q) begin
                    key    <= key + KEY_W'(1);
                    dir_up <= 1'b1;
                end else begin
                    key <= key - KEY_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/hamming_frame_encoder.sv
// Frame-buffered Hamming encoder: collects up to DEPTH words, adds a
// ping-pong key to each, Hamming-encodes in place and streams the result.
// Optional macro SECDED_PARITY_EN appends an overall parity bit as the MSB.
//
// state  | meaning
// IDLE   | waiting for first word of a frame
// LOAD   | accepting further words into the buffer
// ENCODE | one buffered word keyed and encoded per cycle
// DRAIN  | streaming codewords out, honouring out_ready
module hamming_frame_encoder
    import hamming_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int KEY_W  = 4,
    localparam int CODE_W = DATA_W + parity_count(DATA_W),
`ifdef SECDED_PARITY_EN
    localparam int OUT_W  = CODE_W + 1
`else
    localparam int OUT_W  = CODE_W
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [KEY_W-1:0]  key_max,
    input  logic [KEY_W-1:0]  key_min,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         count;
    logic [AW-1:0]         idx;
    logic [AW-1:0]         rd;
    logic [OUT_W-1:0]      frame_mem [DEPTH];
    logic [KEY_W-1:0]      key;
    logic                  key_load;
    logic                  key_step;
    logic                  in_hs;
    logic                  enc_done;
    logic                  drain_last;
    logic [DATA_W-1:0]     sum;
    logic [MAX_CODE_W-1:0] enc_full;
    logic [OUT_W-1:0]      enc_word;
    logic                  unused_enc;

    assign in_hs      = in_valid & in_ready;
    assign enc_done   = ({1'b0, idx} == count - 1'b1);
    assign drain_last = ({1'b0, rd} == count - 1'b1);

    ping_pong_key_gen #(.KEY_W(KEY_W)) u_key_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (key_load),
        .step  (key_step),
        .min   (key_min),
        .max   (key_max),
        .key   (key)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/key control.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        key_load  = 1'b0;
        key_step  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_last) begin
                        state_nxt = ENCODE;
                        key_load  = 1'b1;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (in_last || count == CW'(DEPTH - 1))) begin
                    state_nxt = ENCODE;
                    key_load  = 1'b1;
                end
            end
            ENCODE: begin
                key_step = 1'b1;
                if (enc_done) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready && drain_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word count, encode index and read pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            idx   <= '0;
            rd    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
                    rd  <= '0;
                    if (in_hs) begin
                        count <= CW'(1);
                    end
                end
                LOAD: begin
                    if (in_hs) begin
                        count <= count + 1'b1;
                    end
                end
                ENCODE: begin
                    idx <= enc_done ? '0 : idx + 1'b1;
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (drain_last) begin
                            count <= '0;
                            rd    <= '0;
                        end else begin
                            rd <= rd + 1'b1;
                        end
                    end
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

    // Keyed sum and its codeword for the word currently being encoded.
    always_comb begin
        sum      = frame_mem[idx][DATA_W-1:0] + DATA_W'(key);
        enc_full = hamming_encode(MAX_DATA_W'(sum), DATA_W);
`ifdef SECDED_PARITY_EN
        enc_word = {^enc_full[CODE_W-1:0], enc_full[CODE_W-1:0]};
`else
        enc_word = enc_full[CODE_W-1:0];
`endif
    end

    assign unused_enc = ^enc_full[MAX_CODE_W-1:CODE_W];

    // Frame buffer: raw words on load, codewords written back in place.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_hs) begin
            frame_mem[0] <= OUT_W'(in_data);
        end else if (state == LOAD && in_hs) begin
            frame_mem[count[AW-1:0]] <= OUT_W'(in_data);
        end else if (state == ENCODE) begin
            frame_mem[idx] <= enc_word;
        end
    end

    assign out_valid = (state == DRAIN);
    assign out_data  = (state == DRAIN) ? frame_mem[rd] : '0;
    assign out_last  = (state == DRAIN) && drain_last;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_hamming_frame_encoder.sv
// Randomised bench for hamming_frame_encoder with a behavioural model of the
// keying and Hamming rules; directed frames cover the known codewords.
module tb_hamming_frame_encoder;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int KEY_W  = 4;
    localparam int CODE_W = 12;
`ifdef SECDED_PARITY_EN
    localparam int OUT_W  = CODE_W + 1;
`else
    localparam int OUT_W  = CODE_W;
`endif

    logic              clk;
    logic              rst_n;
    logic [KEY_W-1:0]  key_max;
    logic [KEY_W-1:0]  key_min;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;
    logic              busy;

    int n_chk = 0;
    int n_bad = 0;
    int words [DEPTH];
    logic [31:0] got_q [$];

    hamming_frame_encoder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .KEY_W(KEY_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_max   (key_max),
        .key_min   (key_min),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Triangle wave between kmin and kmax, evaluated directly from the index.
    function automatic int model_key(input int i, input int kmin, input int kmax);
        int span;
        int phase;
        if (kmin >= kmax) return kmin;
        span  = kmax - kmin;
        phase = i % (2 * span);
        return kmin + ((phase <= span) ? phase : 2 * span - phase);
    endfunction

    function automatic logic [31:0] model_code(input int value);
        logic [31:0] cw;
        logic [31:0] mask;
        int j;
        cw = '0;
        j  = 0;
        for (int pos = 1; pos <= CODE_W; pos++) begin
            if (!$onehot(pos)) begin
                cw[pos-1] = value[j];
                j++;
            end
        end
        for (int k = 0; (1 << k) <= CODE_W; k++) begin
            mask = '0;
            for (int pos = 1; pos <= CODE_W; pos++) begin
                if ((pos & (1 << k)) != 0) mask[pos-1] = 1'b1;
            end
            cw[(1 << k) - 1] = ^(cw & mask);
        end
`ifdef SECDED_PARITY_EN
        cw[CODE_W] = ^cw[CODE_W-1:0];
`endif
        return cw;
    endfunction

    // Offer words[0..n-1]; returns at the posedge that accepts the last one.
    task automatic send_frame(input int n, input int kmin, input int kmax, input bit mark_last);
        int budget;
        key_min = KEY_W'(kmin);
        key_max = KEY_W'(kmax);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            budget = 0;
            while ($urandom_range(0, 3) == 0 && budget < 3) begin
                in_valid = 1'b0;
                budget++;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = DATA_W'(words[i]);
            in_last  = (i == n - 1) && mark_last;
            budget = 0;
            while (!in_ready && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
            @(posedge clk);
        end
        // A stray word stays offered while the frame is processed.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        in_last  = 1'b0;
        chk("enc_in_ready", {31'd0, in_ready}, 32'd0);
    endtask

    // Counts ENCODE cycles from the first negedge after the last input.
    task automatic wait_encode(input int n);
        int lat;
        lat = 0;
        while (!out_valid && lat < 100) begin
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, n);
    endtask

    task automatic drain_frame(input int n, input int kmin, input int kmax, input int stall_pct);
        logic [31:0]      exp_q [$];
        logic [OUT_W-1:0] held;
        bit               stalled;
        int               hs;
        int               budget;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model_code((words[i] + model_key(i, kmin, kmax)) % 256));
        end
        got_q.delete();
        hs = 0;
        stalled = 0;
        budget = 0;
        held = '0;
        while (hs < n && budget < 500) begin
            if (stalled) chk("stall_stable", 32'(out_data), 32'(held));
            chk("drain_valid", {31'd0, out_valid}, 32'd1);
            out_ready = ($urandom_range(0, 99) >= stall_pct);
            if (out_valid && out_ready) begin
                chk("codeword", 32'(out_data), exp_q[hs]);
                chk("out_last", {31'd0, out_last}, {31'd0, (hs == n - 1)});
                got_q.push_back(32'(out_data));
                hs++;
                stalled = 0;
            end else begin
                stalled = out_valid;
                held    = out_data;
            end
            @(negedge clk);
            if (hs == n) begin
                in_valid  = 1'b0;
                out_ready = 1'b0;
            end
            budget++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("handshakes", hs, n);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("valid_after", {31'd0, out_valid}, 32'd0);
        chk("data_after", 32'(out_data), 32'd0);
    endtask

    task automatic run_frame(input int n, input int kmin, input int kmax, input bit mark_last,
                             input int stall_pct);
        send_frame(n, kmin, kmax, mark_last);
        wait_encode(n);
        drain_frame(n, kmin, kmax, stall_pct);
    endtask

    initial begin
        int          n;
        int          kmin;
        int          kmax;
        int          budget;
        logic [31:0] tp8 [8];
        tp8[0] = 32'h000; tp8[1] = 32'h007; tp8[2] = 32'h019; tp8[3] = 32'h007;
        tp8[4] = 32'h000; tp8[5] = 32'h007; tp8[6] = 32'h019; tp8[7] = 32'h007;

        rst_n     = 1'b0;
        key_min   = '0;
        key_max   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #23;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        words[0] = 8'h01;
        run_frame(1, 0, 0, 1'b1, 0);
        chk("tp_single01", got_q[0], 32'h007);

        words[0] = 8'hFF;
        run_frame(1, 0, 0, 1'b1, 30);
        chk("tp_singleFF", got_q[0], 32'hF77);

        for (int i = 0; i < 8; i++) words[i] = 0;
        run_frame(8, 0, 2, 1'b0, 0);
        for (int i = 0; i < 8; i++) chk("tp_pingpong", got_q[i], tp8[i]);

        words[0] = 8'hFE;
        run_frame(1, 2, 2, 1'b1, 0);
        chk("tp_wrap", got_q[0], 32'h000);

        for (int i = 0; i < 5; i++) words[i] = int'($urandom_range(0, 255));
        run_frame(5, 3, 9, 1'b1, 60);
        chk("tp_bp_count", got_q.size(), 5);

        // Reset asserted mid-drain must clear outputs without a clock edge.
        for (int i = 0; i < 3; i++) words[i] = int'($urandom_range(0, 255));
        send_frame(3, 1, 5, 1'b1);
        wait_encode(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_last", {31'd0, out_last}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) words[i] = int'($urandom_range(0, 255));
        run_frame(4, 2, 6, 1'b1, 25);

        for (int f = 0; f < 14; f++) begin
            n    = int'($urandom_range(1, DEPTH));
            kmin = int'($urandom_range(0, 15));
            kmax = int'($urandom_range(0, 15));
            for (int i = 0; i < n; i++) words[i] = int'($urandom_range(0, 255));
            run_frame(n, kmin, kmax, (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 70)));
        end

        budget = 0;
        while (busy && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        chk("final_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
